secded_decoder_pipe: RTL

Parametrised, pipelined SECDED (extended Hamming) decoder with valid/ready flow control and saturating error-statistics counters. It generalises the 11-data/16-code decoder to any DATA_W. It registers the syndrome and corrected output, honours downstream backpressure, and counts corrected and uncorrectable words. It sits between a storage or link receive path and the consuming logic.

---
 rtl/secded_decoder_pipe.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/secded_decoder_pipe.sv
// Pipelined SECDED decoder with saturating corrected/uncorrectable counters.
// Latency is 2 cycles. A stall holds both stages, and in_ready falls only when both stages are full and stalled.
module secded_decoder_pipe #(
  parameter  int DATA_W = 11,
  parameter  int CNT_W  = 16,
  localparam int P      = $clog2(DATA_W + $clog2(DATA_W + 1) + 1),
  localparam int N      = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              correct_en,
  input  logic              clr_cnt,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err,
  output logic              out_unc,
  output logic [P-1:0]      out_syn,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_unc
);

  // Hamming position of data bit j: the j-th position that is not a power of two.
  function automatic int data_pos(input int j);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int k = 1; k < N; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (cnt == j && pos == 0) pos = k;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic [DATA_W-1:0] data1_q, data1_d;
  logic [P-1:0]      syn1_q, syn1_d;
  logic              pmis1_q, pmis1_d;
  logic              cen1_q, cen1_d;
  logic              valid1_q, valid1_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic              out_unc_q, out_unc_d;
  logic [P-1:0]      out_syn_q, out_syn_d;
  logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_W-1:0]  cnt_unc_q, cnt_unc_d;

  logic              s1_load, s2_load, hs;
  logic [P-1:0]      syn_in;
  logic [DATA_W-1:0] data_in, flip, data_fix;
  logic              err, unc, fix_en;

  // Stage 1 keeps only the raw data bits. A correction can only ever flip one of them.
  for (genvar j = 0; j < DATA_W; j++) begin : g_map
    localparam int POS = data_pos(j);
    assign data_in[j] = in_code[POS-1];
    assign flip[j]    = (int'(syn1_q) == POS);
  end

  always_comb begin
    syn_in = '0;
    for (int k = 1; k < N; k++) begin
      if (in_code[k-1]) syn_in = syn_in ^ P'(k);
    end

    s2_load = !out_valid_q || out_ready;
    s1_load = !valid1_q || s2_load;
    hs      = out_valid_q && out_ready;

    err      = (syn1_q != '0) || pmis1_q;
    unc      = (syn1_q != '0) && (!pmis1_q || int'(syn1_q) > N - 1);
    fix_en   = cen1_q && pmis1_q && (syn1_q != '0) && !unc;
    data_fix = data1_q ^ (fix_en ? flip : '0);

    valid1_d    = valid1_q;
    data1_d     = data1_q;
    syn1_d      = syn1_q;
    pmis1_d     = pmis1_q;
    cen1_d      = cen1_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_unc_d   = out_unc_q;
    out_syn_d   = out_syn_q;
    cnt_corr_d  = cnt_corr_q;
    cnt_unc_d   = cnt_unc_q;

    if (s1_load) begin
      valid1_d = in_valid;
      data1_d  = data_in;
      syn1_d   = syn_in;
      pmis1_d  = ^in_code;
      cen1_d   = correct_en;
    end

    if (s2_load) begin
      out_valid_d = valid1_q;
      if (valid1_q) begin
        out_data_d = data_fix;
        out_err_d  = err;
        out_unc_d  = unc;
        out_syn_d  = syn1_q;
      end
    end

    if (clr_cnt) begin
      cnt_corr_d = '0;
      cnt_unc_d  = '0;
    end else if (hs) begin
      if (out_err_q && !out_unc_q && cnt_corr_q != '1) cnt_corr_d = cnt_corr_q + CNT_W'(1);
      if (out_unc_q && cnt_unc_q != '1) cnt_unc_d = cnt_unc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q    <= 1'b0;
      data1_q     <= '0;
      syn1_q      <= '0;
      pmis1_q     <= 1'b0;
      cen1_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_unc_q   <= 1'b0;
      out_syn_q   <= '0;
      cnt_corr_q  <= '0;
      cnt_unc_q   <= '0;
    end else begin
      valid1_q    <= valid1_d;
      data1_q     <= data1_d;
      syn1_q      <= syn1_d;
      pmis1_q     <= pmis1_d;
      cen1_q      <= cen1_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_unc_q   <= out_unc_d;
      out_syn_q   <= out_syn_d;
      cnt_corr_q  <= cnt_corr_d;
      cnt_unc_q   <= cnt_unc_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign out_unc   = out_unc_q;
  assign out_syn   = out_syn_q;
  assign cnt_corr  = cnt_corr_q;
  assign cnt_unc   = cnt_unc_q;

endmodule
